ps2_key_controller: RTL

Sequences raw PS/2 keyboard bytes into synth control events. Sits between the PS/2 byte receiver and the tone generator / amplitude stage.
Tracks make/break prefixes and suppresses typematic repeats. Produces a gated current note with on/off pulses, plus saturating octave and amplitude registers driven by the z/x and 1/2 keys.

---
 rtl/ps2_kb_pkg.sv | 42 ++++
 rtl/ps2_scancode_lut.sv | 38 +++
 rtl/ps2_key_controller.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/ps2_kb_pkg.sv
// rtl/ps2_kb_pkg.sv - shared scancodes, state encodings and widths for the PS/2 key controller
package ps2_kb_pkg;

  localparam int NOTE_W = 4;

  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;

  // Set-2 make codes for one octave of notes, C through B
  localparam logic [7:0] SC_C  = 8'h1C;
  localparam logic [7:0] SC_CS = 8'h1D;
  localparam logic [7:0] SC_D  = 8'h1B;
  localparam logic [7:0] SC_DS = 8'h24;
  localparam logic [7:0] SC_E  = 8'h23;
  localparam logic [7:0] SC_F  = 8'h2B;
  localparam logic [7:0] SC_FS = 8'h2C;
  localparam logic [7:0] SC_G  = 8'h34;
  localparam logic [7:0] SC_GS = 8'h35;
  localparam logic [7:0] SC_A  = 8'h33;
  localparam logic [7:0] SC_AS = 8'h3C;
  localparam logic [7:0] SC_B  = 8'h3B;

  localparam logic [7:0] SC_Z   = 8'h1A;
  localparam logic [7:0] SC_X   = 8'h22;
  localparam logic [7:0] SC_ONE = 8'h16;
  localparam logic [7:0] SC_TWO = 8'h1E;

  typedef enum logic [1:0] {
    CTRL_OCT_DN = 2'd0,
    CTRL_OCT_UP = 2'd1,
    CTRL_AMP_DN = 2'd2,
    CTRL_AMP_UP = 2'd3
  } ctrl_id_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BRK     = 2'd1,
    ST_EXT     = 2'd2,
    ST_EXT_BRK = 2'd3
  } kb_state_t;

endpackage

// File: rtl/ps2_scancode_lut.sv
// rtl/ps2_scancode_lut.sv - classifies a scan byte as note key, control key or neither
module ps2_scancode_lut
  import ps2_kb_pkg::*;
(
  input  logic [7:0]        i_byte,
  output logic              o_is_note,
  output logic [NOTE_W-1:0] o_note_idx,
  output logic              o_is_ctrl,
  output ctrl_id_t          o_ctrl_id
);

  always_comb begin
    o_is_note  = 1'b1;
    o_note_idx = '0;
    o_is_ctrl  = 1'b0;
    o_ctrl_id  = CTRL_OCT_DN;
    case (i_byte)
      SC_C:    o_note_idx = 4'd0;
      SC_CS:   o_note_idx = 4'd1;
      SC_D:    o_note_idx = 4'd2;
      SC_DS:   o_note_idx = 4'd3;
      SC_E:    o_note_idx = 4'd4;
      SC_F:    o_note_idx = 4'd5;
      SC_FS:   o_note_idx = 4'd6;
      SC_G:    o_note_idx = 4'd7;
      SC_GS:   o_note_idx = 4'd8;
      SC_A:    o_note_idx = 4'd9;
      SC_AS:   o_note_idx = 4'd10;
      SC_B:    o_note_idx = 4'd11;
      SC_Z:    begin o_is_note = 1'b0; o_is_ctrl = 1'b1; o_ctrl_id = CTRL_OCT_DN; end
      SC_X:    begin o_is_note = 1'b0; o_is_ctrl = 1'b1; o_ctrl_id = CTRL_OCT_UP; end
      SC_ONE:  begin o_is_note = 1'b0; o_is_ctrl = 1'b1; o_ctrl_id = CTRL_AMP_DN; end
      SC_TWO:  begin o_is_note = 1'b0; o_is_ctrl = 1'b1; o_ctrl_id = CTRL_AMP_UP; end
      default: o_is_note = 1'b0;
    endcase
  end

endmodule

// File: rtl/ps2_key_controller.sv
// rtl/ps2_key_controller.sv - turns PS/2 make/break byte streams into note gate/pulse and octave/amplitude controls
module ps2_key_controller
  import ps2_kb_pkg::*;
#(
  parameter int OCT_DEFAULT = 4,
  parameter int OCT_MAX     = 7,
  parameter int AMP_DEFAULT = 8,
  parameter int AMP_MAX     = 15,
  parameter int TIMEOUT_CYC = 2500000
) (
  input  logic              CLOCK_50,
  input  logic              KEY,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic [NOTE_W-1:0] note,
  output logic              gate,
  output logic              note_on,
  output logic              note_off,
  output logic [2:0]        octave,
  output logic [3:0]        amplitude,
  output logic              seq_err
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [2:0] OCT_MAX_V = 3'(OCT_MAX);
  localparam logic [3:0] AMP_MAX_V = 4'(AMP_MAX);

  kb_state_t         r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [NOTE_W-1:0] r_note, w_note_nxt;
  logic              r_gate, w_gate_nxt;
  logic              r_note_on, w_note_on_nxt;
  logic              r_note_off, w_note_off_nxt;
  logic [2:0]        r_octave, w_octave_nxt;
  logic [3:0]        r_amp, w_amp_nxt;
  logic              r_seq_err, w_seq_err_nxt;
  logic [3:0]        r_held, w_held_nxt;

  logic              w_is_note, w_is_ctrl, w_timeout;
  logic [NOTE_W-1:0] w_note_idx;
  ctrl_id_t          w_ctrl_id;

  ps2_scancode_lut u_lut (
    .i_byte     (byte_data),
    .o_is_note  (w_is_note),
    .o_note_idx (w_note_idx),
    .o_is_ctrl  (w_is_ctrl),
    .o_ctrl_id  (w_ctrl_id)
  );

  // A byte on the expiry cycle takes priority over the timeout
  assign w_timeout = (r_state != ST_IDLE) && !byte_valid && (r_cnt == CNT_LAST);

  always_ff @(posedge CLOCK_50 or negedge KEY) begin
    if (!KEY) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (byte_valid) begin
      case (r_state)
        ST_IDLE: begin
          if (byte_data == SC_BREAK)    w_state_nxt = ST_BRK;
          else if (byte_data == SC_EXT) w_state_nxt = ST_EXT;
        end
        ST_EXT:  w_state_nxt = (byte_data == SC_BREAK) ? ST_EXT_BRK : ST_IDLE;
        default: w_state_nxt = ST_IDLE;
      endcase
    end else if (w_timeout) begin
      w_state_nxt = ST_IDLE;
    end
  end

  always_comb begin
    w_note_nxt     = r_note;
    w_gate_nxt     = r_gate;
    w_note_on_nxt  = 1'b0;
    w_note_off_nxt = 1'b0;
    w_octave_nxt   = r_octave;
    w_amp_nxt      = r_amp;
    w_held_nxt     = r_held;
    w_seq_err_nxt  = w_timeout;
    if (byte_valid) begin
      case (r_state)
        ST_IDLE: begin
          if (w_is_note) begin
            if (!(r_gate && (w_note_idx == r_note))) begin
              w_note_nxt    = w_note_idx;
              w_gate_nxt    = 1'b1;
              w_note_on_nxt = 1'b1;
            end
          end else if (w_is_ctrl && !r_held[w_ctrl_id]) begin
            w_held_nxt[w_ctrl_id] = 1'b1;
            case (w_ctrl_id)
              CTRL_OCT_DN: if (r_octave != 3'd0)     w_octave_nxt = r_octave - 3'd1;
              CTRL_OCT_UP: if (r_octave < OCT_MAX_V) w_octave_nxt = r_octave + 3'd1;
              CTRL_AMP_DN: if (r_amp != 4'd0)        w_amp_nxt = r_amp - 4'd1;
              default:     if (r_amp < AMP_MAX_V)    w_amp_nxt = r_amp + 4'd1;
            endcase
          end
        end
        ST_BRK: begin
          if (w_is_note && r_gate && (w_note_idx == r_note)) begin
            w_gate_nxt     = 1'b0;
            w_note_off_nxt = 1'b1;
          end else if (w_is_ctrl) begin
            w_held_nxt[w_ctrl_id] = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50 or negedge KEY) begin
    if (!KEY) begin
      r_cnt      <= '0;
      r_note     <= '0;
      r_gate     <= 1'b0;
      r_note_on  <= 1'b0;
      r_note_off <= 1'b0;
      r_octave   <= 3'(OCT_DEFAULT);
      r_amp      <= 4'(AMP_DEFAULT);
      r_seq_err  <= 1'b0;
      r_held     <= '0;
    end else begin
      r_cnt      <= (byte_valid || r_state == ST_IDLE) ? '0 : r_cnt + CNT_W'(1);
      r_note     <= w_note_nxt;
      r_gate     <= w_gate_nxt;
      r_note_on  <= w_note_on_nxt;
      r_note_off <= w_note_off_nxt;
      r_octave   <= w_octave_nxt;
      r_amp      <= w_amp_nxt;
      r_seq_err  <= w_seq_err_nxt;
      r_held     <= w_held_nxt;
    end
  end

  assign note      = r_note;
  assign gate      = r_gate;
  assign note_on   = r_note_on;
  assign note_off  = r_note_off;
  assign octave    = r_octave;
  assign amplitude = r_amp;
  assign seq_err   = r_seq_err;

endmodule
